// File: rtl/fsm_arc_monitor.sv
// Arc-coverage and mapping monitor for a one-bit combinational FSM (input a, output b).
// Optional per-arc sample counters are built when FSM_ARC_COUNT_EN is defined.
module fsm_arc_monitor #(
    parameter int X     = 0,
    parameter int CNT_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clear,
    input  logic               a,
    input  logic               b,
    output logic [1:0]         state,
    output logic [3:0]         arc_seen,
    output logic               all_arcs,
    output logic [CNT_W-1:0]   trans_cnt,
    output logic               mismatch,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic [4*CNT_W-1:0] arc_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        TRACK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic INV = (X % 2) != 0;

    state_t           cur, nxt;
    logic             prev_b, prev_b_nx;
    logic [3:0]       arc_seen_nx;
    logic [CNT_W-1:0] trans_nx, mm_cnt_nx;
    logic             mm_nx;
    logic             sample_bad, viol;
    logic [1:0]       idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

`ifdef FSM_ARC_COUNT_EN
    logic [4*CNT_W-1:0] arc_cnt_r, arc_cnt_nx;
    assign arc_cnt = arc_cnt_r;
`else
    assign arc_cnt = '0;
`endif

    assign state = cur;

    always_comb begin
        // An unknown a or b counts as a violation but must not pollute coverage.
        sample_bad  = ((^{a, b}) === 1'bx);
        viol        = sample_bad || (b != (a ^ INV));
        idx         = {prev_b, b};
        nxt         = cur;
        prev_b_nx   = prev_b;
        arc_seen_nx = arc_seen;
        trans_nx    = trans_cnt;
        mm_nx       = 1'b0;
        mm_cnt_nx   = mismatch_cnt;
`ifdef FSM_ARC_COUNT_EN
        arc_cnt_nx  = arc_cnt_r;
`endif
        if (clear) begin
            nxt         = IDLE;
            prev_b_nx   = 1'b0;
            arc_seen_nx = 4'h0;
            trans_nx    = '0;
            mm_cnt_nx   = '0;
`ifdef FSM_ARC_COUNT_EN
            arc_cnt_nx  = '0;
`endif
        end else if (enable) begin
            if (cur != IDLE && viol) begin
                mm_nx     = 1'b1;
                mm_cnt_nx = sat_inc(mismatch_cnt);
            end
            case (cur)
                IDLE: nxt = PRIME;
                PRIME: begin
                    if (!sample_bad) prev_b_nx = b;
                    nxt = TRACK;
                end
                default: begin
                    if (!sample_bad) begin
                        arc_seen_nx = arc_seen | (4'b0001 << idx);
                        if (b != prev_b) trans_nx = sat_inc(trans_cnt);
                        prev_b_nx = b;
`ifdef FSM_ARC_COUNT_EN
                        for (int i = 0; i < 4; i++) begin
                            if (idx == i[1:0])
                                arc_cnt_nx[i*CNT_W +: CNT_W] = sat_inc(arc_cnt_r[i*CNT_W +: CNT_W]);
                        end
`endif
                    end
                    if (cur == TRACK && (&arc_seen_nx)) nxt = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur          <= IDLE;
            prev_b       <= 1'b0;
            arc_seen     <= 4'h0;
            all_arcs     <= 1'b0;
            trans_cnt    <= '0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
`ifdef FSM_ARC_COUNT_EN
            arc_cnt_r    <= '0;
`endif
        end else begin
            cur          <= nxt;
            prev_b       <= prev_b_nx;
            arc_seen     <= arc_seen_nx;
            all_arcs     <= &arc_seen_nx;
            trans_cnt    <= trans_nx;
            mismatch     <= mm_nx;
            mismatch_cnt <= mm_cnt_nx;
`ifdef FSM_ARC_COUNT_EN
            arc_cnt_r    <= arc_cnt_nx;
`endif
        end
    end

endmodule
